// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared NPU constants, status bit map and packer state type
//
// Holds the activation/bus widths, the Avalon register map of the activation
// readback port, the STATUS word bit positions and the packer state enum.
package npu_pkg;

  localparam int ACT_W = 16;
  localparam int BUS_W = 32;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int ST_EMPTY = 16;
  localparam int ST_FULL  = 17;
  localparam int ST_OVF   = 18;
  localparam int ST_HALF  = 19;

  typedef enum logic {
    PK_LO = 1'b0,
    PK_HI = 1'b1
  } pk_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and fall-through head
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (pointers and count only)
//   push       write push_data if there is room, or if a pop frees a slot this edge
//   push_data  word to store
//   pop        drop the head word (ignored while empty)
//   head       oldest stored word, combinational
//   full       count == DEPTH
//   empty      count == 0
//   count      number of stored words, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/act_readback.sv
// rtl/act_readback.sv - packs ReLU activations into 32-bit words for host readback
//
// Ports:
//   CLKEXT         single clock
//   RST_GLO_N      synchronous active-low reset
//   Data_IN        activation sample from the ReLU output register
//   EN_IN          sample strobe
//   FLUSH          pushes a pending half-word, zero-padded
//   chipselect     Avalon-MM select
//   read           Avalon-MM read strobe
//   address        0 = DATA (pop), 1 = STATUS
//   readdata       registered read data
//   readdatavalid  one-cycle read strobe, one cycle after the read
//   full/empty     FIFO occupancy flags
//   overflow       sticky, a packed word was dropped; cleared by a STATUS read
module act_readback
  import npu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ACT_W = npu_pkg::ACT_W
) (
  input  logic             CLKEXT,
  input  logic             RST_GLO_N,
  input  logic [ACT_W-1:0] Data_IN,
  input  logic             EN_IN,
  input  logic             FLUSH,
  input  logic             chipselect,
  input  logic             read,
  input  logic             address,
  output logic [BUS_W-1:0] readdata,
  output logic             readdatavalid,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int WORD_W = 2 * ACT_W;
  localparam int CW     = $clog2(DEPTH) + 1;

  pk_state_t           state;
  logic [ACT_W-1:0]    lo_reg;
  logic                push;
  logic [WORD_W-1:0]   push_word;
  logic [WORD_W-1:0]   head;
  logic [CW-1:0]       count;
  logic                data_rd;
  logic                status_rd;
  logic                pop;
  logic                drop;
  logic [BUS_W-1:0]    status;

  assign data_rd   = chipselect & read & (address == ADDR_DATA);
  assign status_rd = chipselect & read & (address == ADDR_STATUS);
  assign pop       = data_rd & ~empty;
  assign drop      = push & full & ~pop;

  // A sample in HI always completes the pair, so FLUSH only matters when no
  // pair is completed: with a sample in LO it ships that sample alone, and
  // without a sample in HI it ships the held half.
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    if (EN_IN && state == PK_HI) begin
      push      = 1'b1;
      push_word = {Data_IN, lo_reg};
    end else if (EN_IN && FLUSH) begin
      push      = 1'b1;
      push_word = {{ACT_W{1'b0}}, Data_IN};
    end else if (FLUSH && state == PK_HI) begin
      push      = 1'b1;
      push_word = {{ACT_W{1'b0}}, lo_reg};
    end
  end

  always_ff @(posedge CLKEXT) begin
    if (!RST_GLO_N) begin
      state  <= PK_LO;
      lo_reg <= '0;
    end else if (EN_IN) begin
      if (state == PK_LO) begin
        lo_reg <= Data_IN;
        state  <= FLUSH ? PK_LO : PK_HI;
      end else begin
        state <= PK_LO;
      end
    end else if (FLUSH) begin
      state <= PK_LO;
    end
  end

  always_comb begin
    status           = '0;
    status[15:0]     = 16'(count);
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
    status[ST_OVF]   = overflow;
    status[ST_HALF]  = (state == PK_HI);
  end

  always_ff @(posedge CLKEXT) begin
    if (!RST_GLO_N) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      readdatavalid <= chipselect & read;
      if (data_rd) begin
        readdata <= empty ? '0 : BUS_W'(head);
      end else if (status_rd) begin
        readdata <= status;
      end
      // A drop on the clearing edge wins so no drop goes unreported.
      if (drop) begin
        overflow <= 1'b1;
      end else if (status_rd) begin
        overflow <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (CLKEXT),
    .rst_n    (RST_GLO_N),
    .push     (push),
    .push_data(push_word),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

endmodule

// File: doc/act_readback.md
# act_readback

Drains the 16-bit activation stream produced by the NPU ReLU stage back to the host. Each enabled ReLU output is captured, two samples are packed per 32-bit word, and words are buffered in a small FIFO. The HPS reads them over an Avalon-MM slave port. The block sits between the ReLU output register and the lightweight HPS-to-FPGA bridge, as the read end of the activation path.

## Interface
- DEPTH, 16: FIFO depth in 32-bit words; power of two, ≥ 2.
- ACT_W, 16: activation width; the packed word is 2*ACT_W bits.
- CLKEXT  in  1  single clock; all state changes on the rising edge.
- RST_GLO_N  in  1  reset, synchronous, active-low.
- Data_IN  in  16  activation sample, connected to ReLU_OUT.
- EN_IN  in  1  sample strobe; Data_IN is captured on every edge where EN_IN=1.
- FLUSH  in  1  one-cycle pulse; forces out a pending half-word.
- chipselect  in  1  Avalon-MM select.
- read  in  1  Avalon-MM read strobe.
- address  in  1  0 = DATA (pop), 1 = STATUS.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for one cycle when readdata is valid.
- full  out  1  FIFO count == DEPTH.
- empty  out  1  FIFO count == 0.
- overflow  out  1  sticky flag; a packed word was dropped.

## Operation
- The packer is a two-state FSM:
  - LO: the next sample is held in lo_reg, and the FSM moves to HI.
  - HI: the next sample forms the push word {sample, lo_reg}, and the FSM returns to LO.
- FLUSH while in HI, or while in LO with EN_IN=1 in the same cycle, pushes {16'h0000, lo} and the FSM ends in LO.
- A sample and FLUSH in the same cycle while in HI pushes the normal pair; FLUSH is then a no-op.
- FLUSH while in LO with no sample is a no-op.
- A DATA read (chipselect & read & address=0) pops the head word into readdata.
- A DATA read while empty returns 32'h0. Pointers and flags are unchanged.
- A STATUS read returns:
  - [15:0] count, zero-extended.
  - [16] empty.
  - [17] full.
  - [18] overflow.
  - [19] packer in HI.
  - [31:20] 0.
- A STATUS read clears overflow on the same edge. A drop on that same edge sets it again.
- A push while full and no pop on that edge drops the word and sets overflow.
- A push and a pop on the same edge are both performed, including when full (count unchanged) and when count==1. The popped word is always the old head.
- Push while empty with a simultaneous read: the read returns 0 and the new word is stored.
- Read and write pointers wrap modulo DEPTH. count spans 0..DEPTH.

## Timing
- On reset (RST_GLO_N=0 at an edge):
  - Pointers, count and overflow go to 0.
  - Packer goes to LO; lo_reg goes to 0.
  - readdata goes to 0 and readdatavalid to 0.
  - empty=1 and full=0.
- Reset mid-packing discards the pending half. Reset has priority over every other input.
- Push latency: after the edge that captures the second sample, count, empty and full already reflect the new word.
- Read latency is fixed at 1. A read sampled at edge N gives readdata/readdatavalid valid after edge N+1 for one cycle.
- Back-to-back reads on consecutive cycles are allowed, giving one word per cycle.
- No waitrequest; the slave is always ready.
- Throughput: one sample per cycle sustained while the host pops at least one word every two cycles.

## Structure
- Shared package npu_pkg holds:
  - ACT_W and BUS_W=32.
  - The address constants ADDR_DATA and ADDR_STATUS.
  - The status bit indices ST_EMPTY, ST_FULL, ST_OVF and ST_HALF.
  - The packer state enum {PK_LO, PK_HI}.
- One sub-module, sync_fifo, parameterised by width and depth:
  - Contains the pointers, count and storage.
  - push/pop inputs; full/empty/count outputs.
  - Combinational head output.
- The packer FSM, Avalon decode and overflow flag stay in act_readback.

## Test plan
- Reset, then samples 16'h0001, 16'h0002 on consecutive cycles, then a DATA read -> readdata=32'h0002_0001 one cycle after the read, with count going 1→0.
- Single sample 16'h7ABC followed by a FLUSH pulse, then a DATA read -> 32'h0000_7ABC; the STATUS read beforehand shows bit19=1 before the FLUSH and 0 after it.
- 2*DEPTH+2 samples with no reads -> full=1, overflow=1, STATUS=0x0006_0010 (DEPTH=16). The next STATUS read shows overflow=0. DEPTH reads return the first DEPTH words in order.
- FIFO full, then a push and a DATA read on the same edge -> count stays DEPTH, no overflow, the old head is returned, and the new word is read last.
- DATA read while empty -> readdata=0, readdatavalid=1, count=0. Then RST_GLO_N low for one edge mid-pair (packer in HI) -> all outputs at reset values and the next sample lands in the low half.
